// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel/line counters with sync, blank and frame flags, all registered together.
// One-cycle latency from enable to outputs; pix_en_in low freezes every output and suppresses new_frame_out.
module video_timing_gen #(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        pix_en_in,
  output logic [11:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        blank_out,
  output logic        new_frame_out,
  output logic [5:0]  frame_count_out
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST   = 12'(H_TOTAL - 1);
  localparam logic [11:0] H_VIS    = 12'(H_ACTIVE);
  localparam logic [11:0] HS_FIRST = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_LAST  = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
  localparam logic [10:0] VS_FIRST = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_LAST  = 11'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [11:0] hcount_q, hcount_d;
  logic [10:0] vcount_q, vcount_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        blank_q, blank_d;
  logic        new_frame_q, new_frame_d;
  logic [5:0]  frame_count_q, frame_count_d;
  logic        h_wrap, v_wrap;

  // Flags are decoded from the next counts so they land in the same cycle as the counts they describe.
  always_comb begin
    hcount_d      = hcount_q;
    vcount_d      = vcount_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    blank_d       = blank_q;
    new_frame_d   = 1'b0;
    frame_count_d = frame_count_q;
    h_wrap        = (hcount_q == H_LAST);
    v_wrap        = (vcount_q == V_LAST);
    if (pix_en_in) begin
      hcount_d = h_wrap ? 12'd0 : hcount_q + 12'd1;
      if (h_wrap) begin
        vcount_d = v_wrap ? 11'd0 : vcount_q + 11'd1;
      end
      new_frame_d = h_wrap && v_wrap;
      if (new_frame_d) begin
        frame_count_d = frame_count_q + 6'd1;
      end
      hsync_d = (hcount_d >= HS_FIRST) && (hcount_d <= HS_LAST);
      vsync_d = (vcount_d >= VS_FIRST) && (vcount_d <= VS_LAST);
      blank_d = (hcount_d >= H_VIS) || (vcount_d >= V_VIS);
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      hcount_q      <= 12'd0;
      vcount_q      <= 11'd0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      blank_q       <= 1'b0;
      new_frame_q   <= 1'b0;
      frame_count_q <= 6'd0;
    end else begin
      hcount_q      <= hcount_d;
      vcount_q      <= vcount_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      blank_q       <= blank_d;
      new_frame_q   <= new_frame_d;
      frame_count_q <= frame_count_d;
    end
  end

  assign hcount_out      = hcount_q;
  assign vcount_out      = vcount_q;
  assign hsync_out       = hsync_q;
  assign vsync_out       = vsync_q;
  assign blank_out       = blank_q;
  assign new_frame_out   = new_frame_q;
  assign frame_count_out = frame_count_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: default-size instance for line timing, reduced-size instance for frame timing.
module tb_video_timing_gen;

  typedef struct packed {
    logic [11:0] h;
    logic [10:0] v;
    logic        hs;
    logic        vs;
    logic        bl;
    logic        nf;
    logic [5:0]  fc;
  } vt_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b, en_b, rst_s, en_s;
  logic [11:0] hc_b, hc_s;
  logic [10:0] vc_b, vc_s;
  logic hs_b, vs_b, bl_b, nf_b, hs_s, vs_s, bl_s, nf_s;
  logic [5:0] fc_b, fc_s;

  video_timing_gen u_big (
    .clk_in(clk), .rst_in(rst_b), .pix_en_in(en_b),
    .hcount_out(hc_b), .vcount_out(vc_b), .hsync_out(hs_b), .vsync_out(vs_b),
    .blank_out(bl_b), .new_frame_out(nf_b), .frame_count_out(fc_b)
  );

  video_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(2), .V_SYNC(2), .V_BP(2)
  ) u_sml (
    .clk_in(clk), .rst_in(rst_s), .pix_en_in(en_s),
    .hcount_out(hc_s), .vcount_out(vc_s), .hsync_out(hs_s), .vsync_out(vs_s),
    .blank_out(bl_s), .new_frame_out(nf_s), .frame_count_out(fc_s)
  );

  vt_t qb[$];
  vt_t qs[$];
  vt_t mb, ms;
  int n_vec = 0;
  int n_miss = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (!ok) begin
      n_miss++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Reference timing model: flags decoded straight from the raster ranges of the new position.
  function automatic vt_t step(input vt_t s, input bit rst, input bit en,
                               input int ha, input int hfp, input int hsw, input int hbp,
                               input int va, input int vfp, input int vsw, input int vbp);
    vt_t n;
    int h, v;
    n = s;
    if (rst) return '0;
    n.nf = 1'b0;
    if (en) begin
      h = int'(s.h) + 1;
      v = int'(s.v);
      if (h == ha + hfp + hsw + hbp) begin
        h = 0;
        v = v + 1;
        if (v == va + vfp + vsw + vbp) begin
          v = 0;
          n.nf = 1'b1;
          n.fc = s.fc + 6'd1;
        end
      end
      n.h  = 12'(h);
      n.v  = 11'(v);
      n.hs = (h >= ha + hfp) && (h < ha + hfp + hsw);
      n.vs = (v >= va + vfp) && (v < va + vfp + vsw);
      n.bl = (h >= ha) || (v >= va);
    end
    return n;
  endfunction

  task automatic cyc(input bit rb, input bit eb, input bit rs, input bit es);
    @(negedge clk);
    rst_b = rb; en_b = eb; rst_s = rs; en_s = es;
    mb = step(mb, rb, eb, 1920, 88, 44, 148, 1080, 4, 5, 36);
    ms = step(ms, rs, es, 8, 2, 2, 2, 4, 2, 2, 2);
    qb.push_back(mb);
    qs.push_back(ms);
  endtask

  // Monitor: scoreboard pops plus hand-computed line/frame timing checks.
  bit line_full = 0, frame_full = 0, prev_bl = 0, prev_vs = 0;
  int hs_cnt, hs_first, bl_rise, en_cnt_b;
  int vs_cnt, vs_first, en_cnt_s, nf_seen;

  initial begin
    vt_t db, ds, eb, es;
    forever begin
      @(posedge clk);
      #1;
      db = {hc_b, vc_b, hs_b, vs_b, bl_b, nf_b, fc_b};
      ds = {hc_s, vc_s, hs_s, vs_s, bl_s, nf_s, fc_s};
      if (qb.size() > 0) begin
        eb = qb.pop_front();
        chk(db === eb, "big_outputs", 64'(db), 64'(eb));
      end
      if (qs.size() > 0) begin
        es = qs.pop_front();
        chk(ds === es, "small_outputs", 64'(ds), 64'(es));
      end

      if (rst_b) begin
        line_full = 0;
        prev_bl = 0;
      end else if (en_b) begin
        if (hc_b == 12'd0) begin
          if (line_full) begin
            chk(hs_cnt == 44, "hsync_width", 64'(hs_cnt), 64'd44);
            chk(hs_first == 2008, "hsync_first", 64'(hs_first), 64'd2008);
            chk(bl_rise == 1920, "blank_rise", 64'(bl_rise), 64'd1920);
            chk(en_cnt_b == 2200, "line_length", 64'(en_cnt_b), 64'd2200);
          end
          line_full = 1;
          hs_cnt = 0; hs_first = -1; bl_rise = -1; en_cnt_b = 0;
        end
        en_cnt_b++;
        if (hs_b) begin
          if (hs_first < 0) hs_first = int'(hc_b);
          hs_cnt++;
        end
        if (bl_b && !prev_bl && bl_rise < 0) bl_rise = int'(hc_b);
        prev_bl = bl_b;
      end

      if (rst_s) begin
        frame_full = 0;
        nf_seen = 0;
      end else begin
        if (!en_s) chk(nf_s == 1'b0, "nf_on_disabled", 64'(nf_s), 64'd0);
        if (vs_s != prev_vs) chk(hc_s == 12'd0, "vsync_edge_h0", 64'(hc_s), 64'd0);
        if (en_s) begin
          if (nf_s) begin
            nf_seen++;
            if (nf_seen == 63) chk(fc_s == 6'd63, "fc_at_63", 64'(fc_s), 64'd63);
            if (nf_seen == 64) chk(fc_s == 6'd0, "fc_wrap_64", 64'(fc_s), 64'd0);
            if (frame_full) begin
              chk(en_cnt_s == 140, "frame_length", 64'(en_cnt_s), 64'd140);
              chk(vs_cnt == 28, "vsync_width", 64'(vs_cnt), 64'd28);
              chk(vs_first == 6, "vsync_first_line", 64'(vs_first), 64'd6);
            end
            frame_full = 1;
            vs_cnt = 0; vs_first = -1; en_cnt_s = 0;
          end
          en_cnt_s++;
          if (vs_s) begin
            if (vs_first < 0) vs_first = int'(vc_s);
            vs_cnt++;
          end
        end
      end
      prev_vs = vs_s;
    end
  end

  initial begin
    rst_b = 1'b1; en_b = 1'b1; rst_s = 1'b1; en_s = 1'b0;
    mb = '0;
    ms = '0;
    // Reset with enable high and low: reset wins.
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 1'b1, 1'(i));
    repeat (2205) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    // Random 50% enable.
    repeat (6000) cyc(1'b0, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
    // Mid-line reset on the default instance.
    while (mb.h != 12'd1500) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    repeat (20) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    // Mid-frame reset on the reduced instance.
    while (!(ms.h == 12'd9 && ms.v == 11'd3)) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (300) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    // Fresh reset, then 65 frames to pass the modulo-64 wrap.
    cyc(1'b0, 1'b1, 1'b1, 1'b1);
    repeat (65 * 140 + 20) cyc(1'b0, 1'b1, 1'b0, 1'b1);
    @(posedge clk);
    #3;
    chk(qb.size() == 0 && qs.size() == 0, "scoreboard_drain", 64'(qb.size() + qs.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
